dm_burst_reader: RTL
====================

Name: dm_burst_reader

Overview:
- Read-side initiator for the data memory (DM) word interface.
- On a start command it walks a contiguous, word-aligned range of DM addresses and drives DMA with DMWE held low.
- It captures each combinational DM read word and streams it out over a valid/ready handshake.
- It keeps a running 32-bit checksum; uses are memory dumps, self-check, and future DMA/debug paths next to the single-cycle datapath.

Parameters:
- DM_WORDS, 1024, DM depth in 32-bit words; byte address space is 0 .. 4*DM_WORDS-4.
- CNT_W, 11, width of word_count; must hold the value DM_WORDS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  command strobe; sampled only in IDLE.
- base_addr  input  32  byte address of the first word; latched on an accepted start.
- word_count  input  CNT_W  number of words to read; latched on an accepted start.
- DMA  output  32  DM byte address, registered.
- DMWE  output  1  DM write enable; constant 0.
- DM  input  32  DM combinational read data for the current DMA.
- rd_data  output  32  word being presented downstream.
- rd_valid  output  1  rd_data is valid.
- rd_ready  input  1  downstream accepts rd_data.
- rd_last  output  1  current word is the final word of the burst; qualified by rd_valid.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse when a command completes.
- err_align  output  1  sticky error: last command had a misaligned base address.
- checksum  output  32  sum mod 2^32 of all words fetched in the current or last burst.

Behaviour:
- Reset (reset==0 at a posedge):
  - state=IDLE.
  - DMA=0, DMWE=0, rd_data=0, rd_valid=0, rd_last=0, busy=0, done=0, err_align=0, checksum=0.
  - A reset mid-burst aborts immediately; no done pulse, no further DM accesses.
- FSM states: IDLE, FETCH, SEND, FIN.
- IDLE, start==1 accepted:
  - Always clears checksum and err_align.
  - If base_addr[1:0]!=0: set err_align=1, pulse done next cycle, stay IDLE, DMA unchanged.
  - Else if word_count==0: pulse done next cycle, stay IDLE.
  - Else: DMA<=base_addr, remaining<=word_count, busy<=1, go to FETCH.
- FETCH, one cycle:
  - rd_data<=DM, checksum<=checksum+DM (mod 2^32).
  - rd_valid<=1, rd_last<=(remaining==1); go to SEND.
- SEND:
  - rd_data, rd_last and DMA hold while rd_valid && !rd_ready.
  - On a handshake (rd_valid && rd_ready at the edge): rd_valid<=0, remaining<=remaining-1.
  - If rd_last: busy<=0, go to FIN.
  - Else: DMA<=next address, go to FETCH.
- FIN: done=1 for exactly this cycle, then IDLE. busy is already 0 in FIN.
- Address increment:
  - next = DMA+4.
  - If next == 4*DM_WORDS, next = 0 (wrap-around).
  - base_addr values at or above 4*DM_WORDS are reduced modulo 4*DM_WORDS when latched.
- Throughput and latency:
  - Throughput is 1 word per 2 cycles with rd_ready tied high.
  - Latency: start accepted at edge k gives DMA valid after edge k and rd_valid after edge k+1.
- start while busy or in FIN is ignored.
- DMWE is never asserted. The block assumes DM read data settles within the cycle DMA is stable.
- word_count==DM_WORDS is legal: reads the whole memory once, wrapping if base_addr!=0.

Decomposition:
- Shared package (e.g. dm_pkg):
  - FSM state encoding (IDLE/FETCH/SEND/FIN).
  - DM_WORDS default.
  - Word size constant 4.
- One small sub-module is natural: dm_addr_wrap.
  - Combinational next-address with wrap.
  - Reused by future DM initiators (writer/loader).

Test Plan:
1. Preload DM[4]=1, DM[8]=2. start, base_addr=4, word_count=2, rd_ready=1.
   - DMA=4 then 8.
   - rd_data 1 (rd_last=0) then 2 (rd_last=1).
   - checksum=3; done pulses one cycle after the second handshake; busy low; DMWE stays 0.
2. Same command, with rd_ready low for 3 cycles on the first word.
   - rd_data holds 1 with rd_valid=1 and DMA=4 for all 3 cycles.
   - Completes identically once rd_ready rises.
3. base_addr=6, word_count=2.
   - err_align=1, done pulse, rd_valid never asserts, DMA unchanged.
   - A following valid start clears err_align.
4. Wrap: DM[4092]=0xFFFFFFFF, DM[0]=2, base_addr=4092, word_count=2.
   - DMA=4092 then 0; checksum=1 (mod 2^32 wrap).
5. word_count=0 → done pulse next cycle, busy never asserts, checksum=0. A start pulsed during a busy burst has no effect.
6. Drive reset=0 during SEND of word 1 of a 3-word burst.
   - Next edge: all outputs at reset values, no done pulse.
   - A new start after reset=1 runs normally.

Source files
------------

// File: rtl/dm_burst_reader_pkg.sv
// Shared definitions for data-memory initiators: state encoding, DM geometry
// and a byte-span helper.
package dm_burst_reader_pkg;

  localparam int DM_WORDS_DEF = 1024;
  localparam int WORD_BYTES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_FIN   = 2'd3
  } dm_state_t;

  function automatic logic [31:0] dm_bytes(input int words);
    return 32'(words * WORD_BYTES);
  endfunction

endpackage

// File: rtl/dm_burst_reader_addr_wrap.sv
// Next word address in DM byte space, wrapping from the last word back to 0.
module dm_burst_reader_addr_wrap
  import dm_burst_reader_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF
) (
  input  logic [31:0] addr,
  output logic [31:0] next_addr
);

  logic [31:0] inc;

  assign inc       = addr + 32'(WORD_BYTES);
  assign next_addr = (inc == dm_bytes(DM_WORDS)) ? 32'd0 : inc;

endmodule

// File: rtl/dm_burst_reader.sv
// Read-only DM burst initiator: walks a word range, streams each word over
// valid/ready and keeps a running 32-bit checksum.
//
// state | meaning
// IDLE  | waiting for start; rejects misaligned or empty commands
// FETCH | capture DM at current DMA, accumulate checksum
// SEND  | present rd_data until the downstream handshake
// FIN   | one-cycle done pulse, back to IDLE
module dm_burst_reader
  import dm_burst_reader_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic [31:0]      DMA,
  output logic             DMWE,
  input  logic [31:0]      DM,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic             busy,
  output logic             done,
  output logic             err_align,
  output logic [31:0]      checksum
);

  localparam logic [31:0] DM_BYTES = dm_bytes(DM_WORDS);

  dm_state_t        state;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      next_addr;

  dm_burst_reader_addr_wrap #(.DM_WORDS(DM_WORDS)) u_wrap (
    .addr      (DMA),
    .next_addr (next_addr)
  );

  assign DMWE = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      DMA       <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_align <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            checksum  <= '0;
            err_align <= 1'b0;
            if (base_addr[1:0] != 2'b00) begin
              err_align <= 1'b1;
              done      <= 1'b1;
            end else if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              // out-of-range bases alias onto the DM image
              DMA       <= base_addr % DM_BYTES;
              remaining <= word_count;
              busy      <= 1'b1;
              state     <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          rd_data  <= DM;
          checksum <= checksum + DM;
          rd_valid <= 1'b1;
          rd_last  <= (remaining == CNT_W'(1));
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (rd_valid && rd_ready) begin
            rd_valid  <= 1'b0;
            remaining <= remaining - CNT_W'(1);
            if (rd_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              DMA   <= next_addr;
              state <= ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
